// File: rtl/inst_memory_loader.sv
// Instruction memory with a byte-serial loader on the UART side.
// Fetch side reads mem[pc] into inst with one cycle of latency.
//
// Ports:
//   CLK            system clock, rising edge
//   reset          asynchronous, active-low reset
//   pc             fetch word address
//   inst           fetched word, registered
//   loader_enable  level, high while a load session is active
//   loader_ready   one-cycle strobe, loader_data is valid
//   loader_data    received byte
//   loader_busy    high while the loader FSM is not idle
//   load_done      one-cycle pulse at a clean session end
//   load_error     one-cycle pulse when a session ends mid-word
//   loaded_words   words committed in the current/last session
//   checksum       mod-256 sum of bytes accepted in the current/last session

module inst_memory_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   pc,
   output logic [8*WORD_BYTES-1:0] inst,
   input  logic                    loader_enable,
   input  logic                    loader_ready,
   input  logic [7:0]              loader_data,
   output logic                    loader_busy,
   output logic                    load_done,
   output logic                    load_error,
   output logic [ADDR_WIDTH:0]     loaded_words,
   output logic [7:0]              checksum
);

   localparam int W     = 8 * WORD_BYTES;
   localparam int IW    = $clog2(WORD_BYTES + 1);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);
   localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                state;
   logic [IW-1:0]         byte_idx;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [W-1:0]          word_buf;
   logic [IW-1:0]         slot;

   logic [W-1:0] mem [DEPTH];

   // Byte slot of the incoming byte inside the assembled word.
   always_comb begin
      slot = byte_idx;
      if (BIG_ENDIAN) begin
         slot = LAST - byte_idx;
      end
   end

   // Storage has no reset so a warm reset keeps the loaded program.
   always_ff @(posedge CLK) begin
      if (state == COMMIT) begin
         mem[waddr] <= word_buf;
      end
   end

   // Nonblocking read of mem gives old data on a same-address write.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         inst <= '0;
      end else begin
         inst <= mem[pc];
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         byte_idx     <= '0;
         waddr        <= '0;
         word_buf     <= '0;
         loaded_words <= '0;
         checksum     <= '0;
         loader_busy  <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         load_done  <= 1'b0;
         load_error <= 1'b0;
         unique case (state)
            IDLE: begin
               byte_idx    <= '0;
               loader_busy <= loader_enable;
               if (loader_enable) begin
                  // Counters hold in IDLE and restart with the session.
                  loaded_words <= '0;
                  checksum     <= '0;
                  waddr        <= '0;
                  state        <= RECV;
               end
            end
            RECV: begin
               if (!loader_enable) begin
                  // A byte strobed in this cycle is dropped.
                  if (byte_idx != '0) begin
                     load_error <= 1'b1;
                  end else begin
                     load_done <= 1'b1;
                  end
                  byte_idx    <= '0;
                  loader_busy <= 1'b0;
                  state       <= IDLE;
               end else begin
                  loader_busy <= 1'b1;
                  if (loader_ready) begin
                     for (int k = 0; k < WORD_BYTES; k++) begin
                        if (slot == IW'(k)) begin
                           word_buf[8*k +: 8] <= loader_data;
                        end
                     end
                     checksum <= checksum + loader_data;
                     byte_idx <= byte_idx + 1'b1;
                     if (byte_idx == LAST) begin
                        state <= COMMIT;
                     end
                  end
               end
            end
            COMMIT: begin
               // waddr wraps naturally; the word count saturates.
               waddr    <= waddr + 1'b1;
               byte_idx <= '0;
               if (loaded_words != FULL) begin
                  loaded_words <= loaded_words + 1'b1;
               end
               loader_busy <= loader_enable;
               if (loader_enable) begin
                  state <= RECV;
               end else begin
                  load_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               loader_busy <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_memory_loader.sv
// Directed bench for inst_memory_loader: a default little-endian
// instance and a 4-word big-endian instance share the byte stream.

module tb_inst_memory_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] pc;
   logic [7:0] data;
   logic       ready;
   logic       le_en;
   logic       be_en;

   logic [31:0] le_inst;
   logic        le_busy;
   logic        le_done;
   logic        le_err;
   logic [10:0] le_words;
   logic [7:0]  le_sum;

   logic [31:0] be_inst;
   logic        be_busy;
   logic        be_done;
   logic        be_err;
   logic [2:0]  be_words;
   logic [7:0]  be_sum;

   int n_vec = 0;
   int n_err = 0;
   int le_done_n = 0;
   int le_err_n = 0;
   int be_done_n = 0;
   int be_err_n = 0;

   always #5 clk = ~clk;

   inst_memory_loader u_le (
      .CLK           (clk),
      .reset         (rst_n),
      .pc            (pc),
      .inst          (le_inst),
      .loader_enable (le_en),
      .loader_ready  (ready),
      .loader_data   (data),
      .loader_busy   (le_busy),
      .load_done     (le_done),
      .load_error    (le_err),
      .loaded_words  (le_words),
      .checksum      (le_sum)
   );

   inst_memory_loader #(
      .ADDR_WIDTH (2),
      .WORD_BYTES (4),
      .BIG_ENDIAN (1'b1)
   ) u_be (
      .CLK           (clk),
      .reset         (rst_n),
      .pc            (pc[1:0]),
      .inst          (be_inst),
      .loader_enable (be_en),
      .loader_ready  (ready),
      .loader_data   (data),
      .loader_busy   (be_busy),
      .load_done     (be_done),
      .load_error    (be_err),
      .loaded_words  (be_words),
      .checksum      (be_sum)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (le_done) le_done_n++;
      if (le_err) le_err_n++;
      if (be_done) be_done_n++;
      if (be_err) be_err_n++;
   endtask

   task automatic send(input logic [7:0] b);
      data  = b;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      tick();
   endtask

   task automatic clr_cnt();
      le_done_n = 0;
      le_err_n  = 0;
      be_done_n = 0;
      be_err_n  = 0;
   endtask

   logic [31:0] be_exp [4];

   initial begin
      rst_n = 1'b0;
      pc    = '0;
      data  = '0;
      ready = 1'b0;
      le_en = 1'b0;
      be_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inst", le_inst, 0);
      chk("rst_busy", le_busy, 0);
      chk("rst_done", le_done, 0);
      chk("rst_err", le_err, 0);
      chk("rst_words", le_words, 0);
      chk("rst_sum", le_sum, 0);
      rst_n = 1'b1;
      tick();

      // Little-endian single word, clean end.
      clr_cnt();
      le_en = 1'b1;
      tick();
      chk("t1_busy", le_busy, 1);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'hEC);
      le_en = 1'b0;
      tick();
      tick();
      chk("t1_done", le_done_n, 1);
      chk("t1_err", le_err_n, 0);
      chk("t1_words", le_words, 1);
      chk("t1_sum", le_sum, 8'hEC);
      chk("t1_idle", le_busy, 0);
      pc = 10'd0;
      tick();
      chk("t1_inst", le_inst, 32'hEC000000);

      // Read-before-write with pc held on the word being committed.
      clr_cnt();
      le_en = 1'b1;
      tick();
      send(8'h01);
      send(8'h02);
      send(8'h03);
      data  = 8'h04;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("t5_old", le_inst, 32'hEC000000);
      tick();
      chk("t5_new", le_inst, 32'h04030201);
      send(8'hA5);
      send(8'h5A);
      send(8'hC3);
      send(8'h3C);
      le_en = 1'b0;
      tick();
      tick();
      chk("t5_words", le_words, 2);
      chk("t5_sum", le_sum, 8'h08);
      chk("t5_done", le_done_n, 1);
      pc = 10'd1;
      tick();
      tick();
      chk("t5_mem1", le_inst, 32'h3CC35AA5);

      // Partial word; last strobe coincides with enable falling.
      clr_cnt();
      le_en = 1'b1;
      tick();
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      send(8'h55);
      send(8'h66);
      le_en = 1'b0;
      data  = 8'hFF;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      chk("t3_err", le_err_n, 1);
      chk("t3_done", le_done_n, 0);
      chk("t3_words", le_words, 1);
      chk("t3_sum", le_sum, 8'h65);
      pc = 10'd0;
      tick();
      tick();
      chk("t3_mem0", le_inst, 32'h44332211);
      pc = 10'd1;
      tick();
      tick();
      chk("t3_mem1", le_inst, 32'h3CC35AA5);

      // Big-endian placement, 4-word memory.
      clr_cnt();
      be_en = 1'b1;
      tick();
      chk("t2_busy", be_busy, 1);
      send(8'hEC);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'h20);
      send(8'h00);
      send(8'h00);
      send(8'h01);
      be_en = 1'b0;
      tick();
      tick();
      chk("t2_done", be_done_n, 1);
      chk("t2_words", be_words, 2);
      chk("t2_sum", be_sum, 8'h0D);
      chk("t2_le_quiet", le_done_n + le_err_n, 0);
      pc = 10'd0;
      tick();
      tick();
      chk("t2_mem0", be_inst, 32'hEC000000);
      pc = 10'd1;
      tick();
      tick();
      chk("t2_mem1", be_inst, 32'h20000001);

      // Address wrap and word-count saturation.
      clr_cnt();
      be_en = 1'b1;
      tick();
      for (int n = 1; n <= 5; n++) begin
         send(8'h00);
         send(8'h00);
         send(8'h00);
         send(8'(n));
      end
      be_en = 1'b0;
      tick();
      tick();
      chk("t4_words", be_words, 4);
      chk("t4_sum", be_sum, 8'h0F);
      chk("t4_done", be_done_n, 1);
      chk("t4_err", be_err_n, 0);
      be_exp[0] = 32'd5;
      be_exp[1] = 32'd2;
      be_exp[2] = 32'd3;
      be_exp[3] = 32'd4;
      for (int a = 0; a < 4; a++) begin
         pc = 10'(a);
         tick();
         tick();
         chk($sformatf("t4_mem%0d", a), be_inst, be_exp[a]);
      end

      // Asynchronous reset in the middle of word 1.
      clr_cnt();
      le_en = 1'b1;
      tick();
      send(8'hDE);
      send(8'hAD);
      send(8'hBE);
      send(8'hEF);
      send(8'h12);
      send(8'h34);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", le_busy, 0);
      chk("t6_words", le_words, 0);
      chk("t6_sum", le_sum, 0);
      le_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_pulses", le_done_n + le_err_n, 0);
      pc = 10'd0;
      tick();
      tick();
      chk("t6_mem0", le_inst, 32'hEFBEADDE);
      pc = 10'd1;
      tick();
      tick();
      chk("t6_mem1", le_inst, 32'h3CC35AA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
